player_input_router: RTL and testbench

// - Turns the raw USB keycode word from the NIOS keycode PIO into per-player game action requests for N_PLAYERS block_logic instances.
// - Press-edge detection, frame-timed auto-repeat (delay then repeat) for moves, one-shot rotate/hold/drop.
// - Valid/ready output per player; long-press space game reset replaces the immediate space reset.
// - Sits in the top level between nios_system.keycode_export and the per-player block_logic / Reset_h logic.

---
 rtl/player_input_router_pkg.sv | 48 ++++
 rtl/player_input_router_key_repeat_fsm.sv | 80 ++++++++
 rtl/player_input_router.sv | 121 ++++++++++++
 tb/tb_player_input_router.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/player_input_router_pkg.sv
// Shared action/key-state types and the per-player key map for the input router.
package player_input_router_pkg;

    typedef enum logic [2:0] {
        LEFT  = 3'd0,
        RIGHT = 3'd1,
        DOWN  = 3'd2,
        ROT_L = 3'd3,
        ROT_R = 3'd4,
        HOLD  = 3'd5,
        DROP  = 3'd6
    } action_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_DELAY,
        KS_REPEAT,
        KS_LATCHED
    } key_state_t;

    localparam int N_ACTIONS = 7;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Indexed [player][action]; P3 uses arrows/nav keys, P4 the keypad.
    localparam logic [7:0] KEYMAP [4][7] = '{
        '{8'h04, 8'h07, 8'h16, 8'h14, 8'h08, 8'h06, 8'h1A},
        '{8'h0D, 8'h0F, 8'h0E, 8'h18, 8'h12, 8'h10, 8'h0C},
        '{8'h50, 8'h4F, 8'h51, 8'h52, 8'h4B, 8'h4E, 8'h4D},
        '{8'h5C, 8'h5E, 8'h5A, 8'h5F, 8'h61, 8'h59, 8'h62}
    };

    // Highest-numbered pending action wins (DROP first, LEFT last).
    function automatic action_t pick_action(input logic [N_ACTIONS-1:0] pend);
        action_t sel;
        sel = LEFT;
        for (int a = 0; a < N_ACTIONS; a++) begin
            if (pend[a]) sel = action_t'(a[2:0]);
        end
        return sel;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/player_input_router_key_repeat_fsm.sv
// One action's press/auto-repeat tracker; fire pulses when the action should be requested.
//   state      | meaning
//   KS_IDLE    | key up, waiting for press
//   KS_DELAY   | held, counting frames before auto-repeat starts
//   KS_REPEAT  | held, firing every ARR_PERIOD frames
//   KS_LATCHED | one-shot key held, waiting for release
module key_repeat_fsm
    import player_input_router_pkg::*;
#(
    parameter bit REPEAT_EN  = 1'b1,
    parameter int DAS_DELAY  = 16,
    parameter int ARR_PERIOD = 4,
    parameter int CW         = 6
) (
    input  logic Clk,
    input  logic Reset,
    input  logic hold_idle,
    input  logic key_down,
    input  logic frame_tick,
    output logic fire
);

    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_PERIOD - 1);

    key_state_t state;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= KS_IDLE;
            cnt   <= '0;
        end else if (hold_idle) begin
            state <= KS_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                KS_IDLE: begin
                    cnt <= '0;
                    if (key_down) state <= REPEAT_EN ? KS_DELAY : KS_LATCHED;
                end
                KS_DELAY: begin
                    if (!key_down) begin
                        state <= KS_IDLE;
                    end else if (frame_tick) begin
                        if (cnt == DAS_LAST) begin
                            state <= KS_REPEAT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                KS_REPEAT: begin
                    if (!key_down) begin
                        state <= KS_IDLE;
                    end else if (frame_tick) begin
                        cnt <= (cnt == ARR_LAST) ? '0 : cnt + CW'(1);
                    end
                end
                KS_LATCHED: begin
                    if (!key_down) state <= KS_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fire = 1'b0;
        if (!hold_idle && key_down) begin
            case (state)
                KS_IDLE:   fire = 1'b1;
                KS_DELAY:  fire = frame_tick && (cnt == DAS_LAST);
                KS_REPEAT: fire = frame_tick && (cnt == ARR_LAST);
                default:   fire = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/player_input_router.sv
// Routes the NIOS keycode word into per-player valid/ready action requests,
// with frame-timed auto-repeat and a long-press space game reset.
module player_input_router
    import player_input_router_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int N_KEYS     = 4,
    parameter int DAS_DELAY  = 16,
    parameter int ARR_PERIOD = 4,
    parameter int RESET_HOLD = 60
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [8*N_KEYS-1:0]    keycode,
    input  logic [N_PLAYERS-1:0]   action_ready,
    output logic [N_PLAYERS-1:0]   action_valid,
    output logic [3*N_PLAYERS-1:0] action,
    output logic                   game_reset,
    output logic                   frame_tick
);

    localparam int CW = $clog2(max3(DAS_DELAY, ARR_PERIOD, RESET_HOLD) + 1);

    logic [8*N_KEYS-1:0] kc_q;
    logic [2:0]          fc_sync;
    logic [CW-1:0]       hold_cnt;
    logic                space_down;

    // Matching by code rather than slot keeps slot reordering from looking like a new press.
    function automatic logic key_is_down(input logic [8*N_KEYS-1:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < N_KEYS; s++) begin
            if (code != 8'h00 && kc[8*s +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            kc_q       <= '0;
            fc_sync    <= '0;
            frame_tick <= 1'b0;
        end else begin
            kc_q       <= keycode;
            fc_sync    <= {fc_sync[1:0], frame_clk};
            frame_tick <= fc_sync[1] & ~fc_sync[2];
        end
    end

    assign space_down = key_is_down(kc_q, KEY_SPACE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_cnt <= '0;
        end else if (!space_down) begin
            hold_cnt <= '0;
        end else if (frame_tick && hold_cnt != CW'(RESET_HOLD)) begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end

    assign game_reset = (hold_cnt == CW'(RESET_HOLD));

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic [N_ACTIONS-1:0] fire;
        logic [N_ACTIONS-1:0] pending;
        logic [N_ACTIONS-1:0] pend_next;
        logic                 load;
        logic                 valid_q;
        action_t              pick;
        action_t              act_q;

        for (genvar a = 0; a < N_ACTIONS; a++) begin : g_action
            key_repeat_fsm #(
                .REPEAT_EN  (a <= int'(DOWN)),
                .DAS_DELAY  (DAS_DELAY),
                .ARR_PERIOD (ARR_PERIOD),
                .CW         (CW)
            ) u_key (
                .Clk        (Clk),
                .Reset      (Reset),
                .hold_idle  (game_reset),
                .key_down   (key_is_down(kc_q, KEYMAP[p][a])),
                .frame_tick (frame_tick),
                .fire       (fire[a])
            );
        end

        // A fresh event on the action being issued re-arms its pending bit.
        always_comb begin
            load      = !valid_q || action_ready[p];
            pick      = pick_action(pending);
            pend_next = pending;
            if (load && |pending) pend_next[pick] = 1'b0;
            pend_next = pend_next | fire;
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                pending <= '0;
                valid_q <= 1'b0;
                act_q   <= LEFT;
            end else if (game_reset) begin
                pending <= '0;
                valid_q <= 1'b0;
            end else begin
                pending <= pend_next;
                if (load) begin
                    valid_q <= |pending;
                    if (|pending) act_q <= pick;
                end
            end
        end

        assign action_valid[p]     = valid_q;
        assign action[3*p +: 3]    = act_q;
    end

endmodule

// File: tb/tb_player_input_router.sv
// Directed bench for player_input_router: latency, priority, auto-repeat timing, one-shot, long-press reset.
module tb_player_input_router;
    import player_input_router_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [31:0] keycode = '0;
    logic [3:0]  action_ready = '0;
    logic [3:0]  action_valid;
    logic [11:0] action;
    logic        game_reset;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int hs [4][8];
    int ticks;
    int base;

    player_input_router #(
        .N_PLAYERS  (4),
        .N_KEYS     (4),
        .DAS_DELAY  (16),
        .ARR_PERIOD (4),
        .RESET_HOLD (60)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .action_ready (action_ready),
        .action_valid (action_valid),
        .action       (action),
        .game_reset   (game_reset),
        .frame_tick   (frame_tick)
    );

    always #10 Clk = ~Clk;

    // Inputs change just after posedge, so the negedge view equals what the next posedge sees.
    always @(negedge Clk) begin
        if (frame_tick) ticks <= ticks + 1;
        for (int p = 0; p < 4; p++) begin
            if (action_valid[p] && action_ready[p])
                hs[p][action[3*p +: 3]] <= hs[p][action[3*p +: 3]] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            step(4);
            frame_clk = 1'b0;
            step(4);
        end
    endtask

    initial begin
        ticks = 0;
        step(3);
        chk("rst_valid", 32'(action_valid), 32'h0);
        chk("rst_action", 32'(action), 32'h0);
        chk("rst_game_reset", 32'(game_reset), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        Reset = 1'b0;
        step(2);

        // ROT_L (14) and ROT_R (08) together, consumer stalled: ROT_R wins and is held.
        keycode = 32'h0000_0814;
        step(2);
        chk("lat_not_yet", 32'(action_valid[0]), 32'h0);
        step(1);
        chk("lat_valid", 32'(action_valid[0]), 32'h1);
        chk("prio_first", 32'(action[2:0]), 32'(ROT_R));
        keycode = '0;
        step(4);
        chk("stall_hold", 32'({action_valid[0], action[2:0]}), 32'({1'b1, ROT_R}));
        action_ready = 4'hF;
        step(1);
        chk("prio_second", 32'({action_valid[0], action[2:0]}), 32'({1'b1, ROT_L}));
        step(1);
        chk("drain_empty", 32'(action_valid[0]), 32'h0);
        chk("rot_r_count", 32'(hs[0][ROT_R]), 32'd1);
        chk("rot_l_count", 32'(hs[0][ROT_L]), 32'd1);

        base = ticks;
        frame_pulse(1);
        chk("tick_per_frame", 32'(ticks - base), 32'd1);

        // LEFT held 39 frames: press + frames 16,20,24,28,32,36.
        base = hs[0][LEFT];
        keycode = 32'h0000_0004;
        frame_pulse(15);
        chk("das_before", 32'(hs[0][LEFT] - base), 32'd1);
        frame_pulse(1);
        chk("das_first", 32'(hs[0][LEFT] - base), 32'd2);
        frame_pulse(23);
        keycode = '0;
        step(6);
        chk("arr_total", 32'(hs[0][LEFT] - base), 32'd7);
        chk("arr_idle", 32'(action_valid), 32'h0);

        // P2 DROP is one-shot however long it is held.
        base = hs[1][DROP];
        keycode = 32'h0000_000C;
        frame_pulse(100);
        keycode = '0;
        step(4);
        chk("drop_once", 32'(hs[1][DROP] - base), 32'd1);

        // Long-press space.
        keycode = 32'h0000_002C;
        frame_pulse(59);
        chk("space_59", 32'(game_reset), 32'h0);
        frame_pulse(1);
        chk("space_60", 32'(game_reset), 32'h1);
        base = hs[0][LEFT];
        keycode = 32'h0000_042C;
        step(6);
        chk("gr_no_valid", 32'(action_valid), 32'h0);
        frame_pulse(2);
        chk("gr_saturate", 32'(game_reset), 32'h1);
        chk("gr_no_left", 32'(hs[0][LEFT] - base), 32'd0);
        keycode = '0;
        step(2);
        chk("space_release", 32'(game_reset), 32'h0);
        step(4);
        chk("gr_after_idle", 32'(action_valid), 32'h0);

        // P1 LEFT and P2 LEFT in the upper slots at once.
        action_ready = 4'h0;
        keycode = 32'h0D04_0000;
        step(3);
        chk("dual_valid", 32'(action_valid), 32'h3);
        chk("dual_p1_act", 32'(action[2:0]), 32'(LEFT));
        chk("dual_p2_act", 32'(action[5:3]), 32'(LEFT));
        action_ready = 4'hF;
        step(1);
        chk("dual_drain", 32'(action_valid), 32'h0);
        keycode = '0;
        step(3);

        // Reset while LEFT is auto-repeating and a request is stalled.
        keycode = 32'h0000_0004;
        frame_pulse(20);
        action_ready = 4'h0;
        frame_pulse(4);
        chk("pre_reset_valid", 32'({action_valid[0], action[2:0]}), 32'({1'b1, LEFT}));
        Reset = 1'b1;
        keycode = '0;
        #1;
        chk("async_rst_valid", 32'(action_valid), 32'h0);
        chk("async_rst_action", 32'(action), 32'h0);
        step(2);
        Reset = 1'b0;
        action_ready = 4'hF;
        step(20);
        chk("post_rst_quiet", 32'(action_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
